// File: rtl/router_switch_alloc.sv
// router_switch_alloc: N-port wormhole switch allocator, RR or fixed-priority.
// Ports: req_valid/req_dir/req_tail/err_clr in; grant/ctrl/err out; clk, rst_n.
module router_switch_alloc #(
  parameter int NPORT    = 3,
  parameter int SELW     = $clog2(NPORT+1),
  parameter int ARB_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NPORT-1:0]      req_valid,
  input  logic [NPORT*SELW-1:0] req_dir,
  input  logic [NPORT-1:0]      req_tail,
  input  logic                  err_clr,
  output logic [NPORT-1:0]      grant,
  output logic [NPORT*SELW-1:0] ctrl,
  output logic [NPORT-1:0]      err
);

  typedef logic [SELW-1:0] sel_t;

  logic [NPORT-1:0] lock_q;
  logic [NPORT-1:0] lock_d;
  sel_t             owner_q [NPORT];
  sel_t             owner_d [NPORT];
  sel_t             ptr_q   [NPORT];
  sel_t             ptr_d   [NPORT];
  logic [NPORT-1:0] err_q;
  logic [NPORT-1:0] err_d;

  sel_t             dir     [NPORT];
  logic [NPORT-1:0] dir_ok;
  logic [NPORT-1:0] owns;

  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      dir[i]    = req_dir[i*SELW +: SELW];
      dir_ok[i] = (dir[i] != '0) &&
                  (dir[i] <= sel_t'(NPORT));
    end
  end

  // An input owning an output is not free and
  // does not take part in arbitration.
  always_comb begin
    owns = '0;
    for (int o = 0; o < NPORT; o++) begin
      for (int i = 0; i < NPORT; i++) begin
        if (lock_q[o] && owner_q[o] == sel_t'(i)) begin
          owns[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q <= '0;
      err_q  <= '0;
      for (int o = 0; o < NPORT; o++) begin
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
      end
    end else begin
      lock_q <= lock_d;
      err_q  <= err_d;
      for (int o = 0; o < NPORT; o++) begin
        owner_q[o] <= owner_d[o];
        ptr_q[o]   <= ptr_d[o];
      end
    end
  end

  always_comb begin
    logic found;
    int   idx;
    found   = 1'b0;
    idx     = 0;
    lock_d  = lock_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    for (int o = 0; o < NPORT; o++) begin
      if (lock_q[o]) begin
        // Tail transfer releases; pointer moves past the owner.
        for (int i = 0; i < NPORT; i++) begin
          if (owner_q[o] == sel_t'(i) &&
              req_valid[i] && req_tail[i]) begin
            lock_d[o]  = 1'b0;
            owner_d[o] = '0;
            ptr_d[o]   = sel_t'((i + 1) % NPORT);
          end
        end
      end else begin
        found = 1'b0;
        for (int k = 0; k < NPORT; k++) begin
          if (ARB_MODE == 1) begin
            idx = k;
          end else begin
            idx = (int'(ptr_q[o]) + k) % NPORT;
          end
          if (!found && !owns[idx] &&
              req_valid[idx] &&
              dir[idx] == sel_t'(o + 1)) begin
            found      = 1'b1;
            lock_d[o]  = 1'b1;
            owner_d[o] = sel_t'(idx);
          end
        end
      end
    end
  end

  // A new error wins over a same-cycle clear.
  always_comb begin
    err_d = err_clr ? '0 : err_q;
    err_d = err_d | (req_valid & ~owns & ~dir_ok);
  end

  always_comb begin
    grant = req_valid & owns;
    err   = err_q;
    ctrl  = '0;
    for (int o = 0; o < NPORT; o++) begin
      if (lock_q[o]) begin
        ctrl[o*SELW +: SELW] = owner_q[o] + sel_t'(1);
      end
    end
  end

endmodule

// File: doc/router_switch_alloc.md
# router_switch_alloc

Parametrised switch allocator for the mesh router. Converts each input port's routing decision (direction code from the routing stage) into per-output data-selector control words, with wormhole locking from head flit to tail flit and round-robin or fixed-priority arbitration when several inputs target the same output. It sits between the routing-algorithm stage and the per-output data selectors, and generalises the fixed three-port direction-to-control translation to N ports with conflict resolution and per-input error flags.

## Interface
Parameters:
- NPORT, 3, number of input ports and output ports (x, y, local at default); 2..8
- SELW, $clog2(NPORT+1), width of one direction code and of one control word
- ARB_MODE, 0, 0 = round-robin per output, 1 = fixed priority (lowest input index wins)

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; asynchronous, active-low
- req_valid  input  NPORT  input i presents a flit this cycle
- req_dir  input  NPORT*SELW  direction code of input i at [i*SELW +: SELW]; 0 = invalid, k = output k-1, k > NPORT invalid
- req_tail  input  NPORT  flit on input i is the last of its packet
- err_clr  input  1  clears all err bits
- grant  output  NPORT  input i's flit is transferred this cycle
- ctrl  output  NPORT*SELW  selector control of output o at [o*SELW +: SELW]; 0 = no source, k = input k-1
- err  output  NPORT  sticky: input i issued an invalid direction

## Operation
- Per-output state: IDLE or LOCKED(owner), plus round-robin pointer ptr[o] in 0..NPORT-1.
- Input i is "free" when it owns no output. Only free inputs arbitrate; an owning input's req_dir is ignored until release.
- IDLE output o: candidates = free inputs with req_valid=1 and req_dir = o+1. ARB_MODE 0: first candidate searching ptr[o], ptr[o]+1, ... wrapping mod NPORT. ARB_MODE 1: lowest index. Winner w: next cycle output o is LOCKED(w), ctrl[o] = w+1.
- An input can win at most one output per cycle (it presents one direction).
- grant[i] = req_valid[i] AND input i owns some output (combinational from registered state). A flit transfers when grant[i]=1.
- Transfer with req_tail[i]=1 releases: next cycle output IDLE, ctrl[o]=0; ptr[o] = (owner+1) mod NPORT. ARB_MODE 1 leaves ptr unused.
- LOCKED output with owner req_valid=0: stays locked, grant 0 (bubble in packet).
- Free input with req_valid=1 and invalid dir (0 or > NPORT): err[i] set next cycle; request ignored, no ctrl change. Set takes priority over err_clr in the same cycle.

## Timing
- Reset values: ctrl all 0, grant all 0, err all 0, all outputs IDLE, all ptr 0.
- Request at cycle t to IDLE output -> ctrl and grant valid at t+1 (1-cycle allocation latency).
- Tail transferred at cycle t -> ctrl[o]=0 at t+1; new allocation earliest at t+2 (one idle cycle per packet boundary, by design).
- Single-flit packet (tail on head): lock at t+1 (grant=1), release at t+2.
- Simultaneous requests from multiple inputs to one output: exactly one winner; losers hold req_valid and retry, no grant.
- Different outputs allocate independently in the same cycle.
- rst_n assertion mid-packet: all state cleared immediately, ctrl=0 asynchronously; partial packet is discarded upstream.
- err_clr alone at t: err=0 at t+1.

## Test plan
- Reset: hold rst_n=0 with random inputs -> ctrl=0, grant=0, err=0; release -> stay 0 until a valid request.
- Single packet (NPORT=3): input0 dir=2, 3 flits, tail on 3rd -> ctrl[1]=1 from next cycle, grant[0]=1 for 3 cycles, ctrl[1]=0 the cycle after the tail.
- Round-robin conflict (ARB_MODE 0): inputs 0 and 2 both dir=1, single-flit, held valid -> ctrl[0]=1, then 0, then 3, then 0, then 1; ARB_MODE 1 -> input0 always wins while requesting.
- Invalid dir: input1 req_dir=0 valid -> err[1]=1 next cycle, ctrl unchanged; err_clr=1 -> err[1]=0; dir=0 plus err_clr in the same cycle -> err[1] stays 1.
- Dir change mid-packet: input2 locked on output0, changes req_dir to 3 before tail -> ctrl[0] stays 3, ctrl[2] stays 0 until release.
- Async reset mid-packet: assert rst_n=0 between clock edges while locked -> ctrl=0 immediately, ptr reset, next allocation restarts from input0.
